// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the FIFO block.
// Drains the FIFO through rd_en / buf_out and presents each word downstream on a
// valid/ready stream. A 2-entry holding buffer (head/tail) absorbs the FIFO's
// one-cycle read latency, so one word per cycle can flow with m_ready held high.
//
// Handshake: a word transfers on every rising edge where m_valid & m_ready.
// While m_valid is high and m_ready is low, m_valid stays high and m_data is held.
// m_valid never depends combinationally on m_ready.
module fifo_rd_stream #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] pop_count,
  output logic [1:0]       dbg_occ,
  output logic             dbg_infl
);

  // Buffer occupancy; the encoding equals the number of words held.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  occ_t             occ_q, occ_d;
  logic             infl_q;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             pop;
  logic             push;
  logic [2:0]       fill;

  assign pop     = m_valid & m_ready;
  assign push    = infl_q;
  assign m_valid = (occ_q != OCC_EMPTY);
  assign m_data  = head_q;

  // Slots committed after this edge: held words plus the in-flight word, minus the
  // word leaving now. pop implies occ >= 1, so this never underflows.
  assign fill = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};

  // Issue a read only when the FIFO has data and a slot will be free for the result.
  assign fifo_rd_en = ~rst & ~fifo_empty & (fill < 3'd2);

  assign dbg_occ  = occ_q;
  assign dbg_infl = infl_q;

  // Next occupancy and buffer contents from push (captured read) and pop.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          occ_d  = OCC_ONE;
          head_d = fifo_dout;
        end
      end
      OCC_ONE: begin
        if (push && !pop) begin
          occ_d  = OCC_TWO;
          tail_d = fifo_dout;
        end else if (push && pop) begin
          head_d = fifo_dout;
        end else if (pop) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // No push can arrive here: a read is never issued with two slots committed.
        if (pop) begin
          occ_d  = OCC_ONE;
          head_d = tail_q;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // State registers; reset discards buffered and in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q     <= OCC_EMPTY;
      infl_q    <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      pop_count <= '0;
    end else begin
      occ_q  <= occ_d;
      infl_q <= fifo_rd_en;
      head_q <= head_d;
      tail_q <= tail_d;
      if (pop) begin
        pop_count <= pop_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds the adapter, and a
// scoreboard checks that words leave in write order with correct handshaking.
module tb_fifo_rd_stream;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
  localparam int N_RANDOM = 10000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic             fifo_empty = 1'b1;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready = 1'b1;
  logic [CNT_W-1:0] pop_count;
  logic [1:0]       dbg_occ;
  logic             dbg_infl;

  fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout (fifo_dout),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .pop_count (pop_count),
    .dbg_occ   (dbg_occ),
    .dbg_infl  (dbg_infl)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_reads  = 0;
  int n_pops   = 0;

  logic [WIDTH-1:0] fq[$];     // words stored in the FIFO model
  logic [WIDTH-1:0] wr_q[$];   // writes pending, visible after the next edge
  logic [WIDTH-1:0] exp_q[$];  // scoreboard: words expected downstream, in order

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- FIFO model (registered read port) ----------------
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      n_reads++;
      if (fq.size() > 0) fifo_dout <= fq.pop_front();
      else fifo_dout <= 'x;
    end
    while (wr_q.size() > 0) fq.push_back(wr_q.pop_front());
    fifo_empty <= (fq.size() == 0);
  end

  // ---------------- monitor / scoreboard ----------------
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] held_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      n_pops = 0;
    end else begin
      check("occ_plus_infl_le_2", 32'(int'(dbg_occ) + int'(dbg_infl) <= 2), 32'd1);
      check("rd_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
      if (hold_prev) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(held_data));
      end
      if (m_valid && m_ready) begin
        check("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("word_order", 32'(m_data), 32'(exp_q.pop_front()));
        n_pops++;
      end
    end
    hold_prev = !rst && m_valid && !m_ready;
    held_data = m_data;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    wr_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // ---------------- directed + random sequence ----------------
  int rd_first, rd_last, rd_n, val_first, val_last, val_n, val_data, reads0, pushed, cycles;

  initial begin
    // Reset with a non-empty FIFO: no read, no output.
    rst = 1'b1;
    m_ready = 1'b1;
    wr_q.push_back(4'hA);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_pop_count", 32'(pop_count), 32'd0);
    end
    check("rst_fifo_nonempty", 32'(fifo_empty), 32'd0);
    fq.delete();
    tick();
    rst = 1'b0;
    tick();

    // Single word: one read in cycle N, word visible in N+2 only.
    push_word(4'h5);
    rd_n = 0; val_n = 0; rd_first = -1; val_first = -1; val_data = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (fifo_rd_en) begin rd_n++; rd_first = i; end
      if (m_valid) begin val_n++; val_first = i; val_data = int'(m_data); end
    end
    check("single_reads", 32'(rd_n), 32'd1);
    check("single_valids", 32'(val_n), 32'd1);
    check("single_latency", 32'(val_first - rd_first), 32'd2);
    check("single_data", 32'(val_data), 32'h5);
    check("single_pop_count", 32'(pop_count), 32'd1);

    // Preloaded 1..8 with m_ready=1: back-to-back reads and deliveries.
    for (int w = 1; w <= 8; w++) push_word(WIDTH'(w));
    rd_n = 0; val_n = 0; rd_first = -1; rd_last = -1; val_first = -1; val_last = -1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (fifo_rd_en) begin
        if (rd_first < 0) rd_first = i;
        rd_last = i;
        rd_n++;
      end
      if (m_valid) begin
        if (val_first < 0) val_first = i;
        val_last = i;
        val_n++;
        check("stream_data", 32'(m_data), 32'(val_n));
      end
    end
    check("stream_reads", 32'(rd_n), 32'd8);
    check("stream_read_span", 32'(rd_last - rd_first + 1), 32'd8);
    check("stream_valids", 32'(val_n), 32'd8);
    check("stream_valid_span", 32'(val_last - val_first + 1), 32'd8);
    check("stream_pop_count", 32'(pop_count), 32'd9);

    // Backpressure: exactly two reads while m_ready=0, then 1..8 back-to-back.
    m_ready = 1'b0;
    reads0 = n_reads;
    for (int w = 1; w <= 8; w++) push_word(WIDTH'(w));
    for (int i = 0; i < 10; i++) tick();
    check("bp_reads", 32'(n_reads - reads0), 32'd2);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_data", 32'(m_data), 32'd1);
    check("bp_occ", 32'(dbg_occ), 32'd2);
    check("bp_pop_count", 32'(pop_count), 32'd9);
    m_ready = 1'b1;
    val_n = 0; val_first = -1; val_last = -1;
    for (int i = 0; i < 14; i++) begin
      if (m_valid) begin
        if (val_first < 0) val_first = i;
        val_last = i;
        val_n++;
        check("bp_stream_data", 32'(m_data), 32'(val_n));
      end
      tick();
    end
    check("bp_valids", 32'(val_n), 32'd8);
    check("bp_valid_span", 32'(val_last - val_first + 1), 32'd8);
    // 17 words delivered so far; a 4-bit counter reads 1.
    check("wrap_pop_count", 32'(pop_count), 32'd1);

    // Reset while the buffer holds two words.
    m_ready = 1'b0;
    for (int w = 0; w < 4; w++) push_word(WIDTH'(4'hC + w));
    for (int i = 0; i < 6; i++) tick();
    check("pre_rst_occ", 32'(dbg_occ), 32'd2);
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_pop_count", 32'(pop_count), 32'd0);
    check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    fq.delete();
    wr_q.delete();
    exp_q.delete();
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_valid", 32'(m_valid), 32'd0);

    // Random writer / reader idles, scoreboarded.
    pushed = 0;
    cycles = 0;
    while ((pushed < N_RANDOM || exp_q.size() != 0) && cycles < 60000) begin
      if (pushed < N_RANDOM && $urandom_range(0, 9) >= 3) begin
        push_word(WIDTH'($urandom_range(0, 15)));
        pushed++;
      end
      m_ready = ($urandom_range(0, 9) >= 3);
      tick();
      cycles++;
    end
    check("random_done", 32'(exp_q.size() == 0 && pushed == N_RANDOM), 32'd1);
    m_ready = 1'b1;
    tick();
    tick();
    check("random_pop_count", 32'(pop_count), 32'(n_pops % (1 << CNT_W)));
    check("random_drained", 32'(m_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
